// File: rtl/zero_ext.sv
// Registered zero-extender with valid/ready flow control and a 2-entry skid buffer.
// Widens an IN_W-bit unsigned operand to OUT_W bits; in_ready is a flop output.
module zero_ext #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  a,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] y,
  output logic             out_valid,
  input  logic             out_ready
);

  if (IN_W < 1 || IN_W > OUT_W) begin : g_param_check
    $error("zero_ext: IN_W must be in 1..OUT_W");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_p1;
  state_t           state_nxt;
  logic [OUT_W-1:0] data_p1;
  logic [OUT_W-1:0] skid_p1;
  logic             in_ready_p1;
  logic             vld_p1;
  logic             accept;
  logic             consume;
  logic             load_out_from_in;
  logic             load_out_from_skid;
  logic             load_skid;

  // Written so that IN_W == OUT_W needs no zero-width replication.
  function automatic logic [OUT_W-1:0] zext(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    r[IN_W-1:0] = v;
    return r;
  endfunction

  assign vld_p1    = (state_p1 != EMPTY);
  assign accept    = in_valid & in_ready_p1;
  assign consume   = vld_p1 & out_ready;
  assign in_ready  = in_ready_p1;
  assign out_valid = vld_p1;
  assign y         = data_p1;

  always_comb begin
    state_nxt          = state_p1;
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    case (state_p1)
      EMPTY: begin
        if (accept) begin
          state_nxt        = ONE;
          load_out_from_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_out_from_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (consume) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_nxt          = ONE;
          load_out_from_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Stage p1: output register, skid register and handshake state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1    <= EMPTY;
      in_ready_p1 <= 1'b1;
      data_p1     <= '0;
      skid_p1     <= '0;
    end else begin
      state_p1    <= state_nxt;
      in_ready_p1 <= (state_nxt != FULL);
      if (load_out_from_in) begin
        data_p1 <= zext(a);
      end else if (load_out_from_skid) begin
        data_p1 <= skid_p1;
      end
      if (load_skid) begin
        skid_p1 <= zext(a);
      end
    end
  end

endmodule

// File: tb/tb_zero_ext.sv
// Bench for zero_ext: vector table, handshake corner sequences and a randomized run
// scored against a FIFO-of-words reference model.
module tb_zero_ext;
  localparam int IN_W  = 7;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [IN_W-1:0]  a = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] y;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: words held in the block, oldest first, plus the last value shown on y.
  int q[$];
  int last_y = 0;

  typedef struct {
    int a_raw;
    int exp_y;
  } vec_t;
  vec_t vecs[6];

  zero_ext #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .a(a), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the handshake rules, then compare all outputs.
  task automatic cycle();
    bit m_acc, m_con;
    int a_word;
    m_acc  = in_valid && (q.size() < 2);
    m_con  = out_ready && (q.size() > 0);
    a_word = int'(a);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      last_y = 0;
    end else begin
      if (m_con) void'(q.pop_front());
      if (m_acc) q.push_back(a_word % (1 << IN_W));
      if (q.size() > 0) last_y = q[0];
    end
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("y", 32'(y), 32'(last_y));
  endtask

  initial begin
    vecs[0] = '{50, 16'h0032};
    vecs[1] = '{250, 16'h007A};
    vecs[2] = '{127, 16'h007F};
    vecs[3] = '{0, 16'h0000};
    vecs[4] = '{85, 16'h0055};
    vecs[5] = '{128, 16'h0000};

    // Reset with an input presented: it must be dropped.
    rst = 1'b1; in_valid = 1'b1; a = 7'd5; out_ready = 1'b1;
    cycle();
    cycle();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset y", 32'(y), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; in_valid = 1'b0;
    cycle();

    // Vector table, one word per cycle with the consumer always ready.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = 7'(vecs[i].a_raw); out_ready = 1'b1;
      cycle();
      check("vec y", 32'(y), 32'(vecs[i].exp_y));
      check("vec upper bits", 32'(y[OUT_W-1:IN_W]), 32'd0);
      check("vec out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    cycle();
    check("drained out_valid", 32'(out_valid), 32'd0);
    check("hold y when idle", 32'(y), 32'd0);

    // Backpressure: fill both registers, then release in order.
    out_ready = 1'b0; in_valid = 1'b1; a = 7'd50;
    cycle();
    a = 7'd60;
    cycle();
    check("bp in_ready", 32'(in_ready), 32'd0);
    check("bp y holds first", 32'(y), 32'd50);
    in_valid = 1'b1; a = 7'd99;
    cycle();
    check("bp full no accept y", 32'(y), 32'd50);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("bp second word", 32'(y), 32'd60);
    check("bp in_ready back", 32'(in_ready), 32'd1);
    cycle();
    check("bp empty", 32'(out_valid), 32'd0);
    check("bp y held", 32'(y), 32'd60);

    // Reset while FULL discards both words.
    out_ready = 1'b0; in_valid = 1'b1; a = 7'd70;
    cycle();
    a = 7'd80;
    cycle();
    check("pre-rst full", 32'(in_ready), 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    cycle();
    check("rst full out_valid", 32'(out_valid), 32'd0);
    check("rst full y", 32'(y), 32'd0);
    check("rst full in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; out_ready = 1'b1;
    cycle();
    check("post-rst idle", 32'(out_valid), 32'd0);
    in_valid = 1'b1; a = 7'd90;
    cycle();
    check("post-rst first word", 32'(y), 32'd90);
    in_valid = 1'b0;
    cycle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 7'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("final empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
